elevador_planificador: RTL and testbench
========================================

Name: elevador_planificador

Overview:
Call scheduler and motion sequencer for the 3-floor elevator. Latches hall/cab calls p1..p3 and tracks position from floor sensors f1..f3. Picks the next target with a SCAN policy (keep direction while calls lie ahead) and drives motor commands mup/mdw. Enforces the overweight interlock and latches a sticky fault on inconsistent sensor activity or travel timeout. Sits between the button/sensor inputs and the motor/display path.

Parameters:
T_VIAJE, 40, max cycles between leaving a floor and reaching the next; exceeding it is a fault.
T_PUERTA, 8, door dwell cycles at a served floor.
T_RETORNO, 64, idle cycles before auto-return (optional feature only).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
p1, p2, p3  input  1 each  call buttons; a level sampled 1 sets the pending bit
f1, f2, f3  input  1 each  floor sensors, 1 = car at that floor
s  input  1  overweight sensor, 1 = overweight
mup  output  1  motor up command
mdw  output  1  motor down command
piso  output  2  current/last floor: 1..3; 0 = unknown
pend  output  3  pending calls, bit0 = floor 1
falla  output  1  sticky fault flag
est  output  3  state: INIT=0, IDLE=1, SUBIR=2, BAJAR=3, PUERTA=4, FALLA=5

Behaviour:
- All inputs are already synchronous to clk. All outputs are registered.
- Reset values: est=INIT, mup=0, mdw=0, piso=0, pend=000, falla=0, timers=0.
- Never mup=mdw=1 simultaneously.
- Sensor "conflict": more than one of f1..f3 sampled 1. Any conflict in any state except FALLA -> FALLA next edge.
- Calls: pX=1 sets pend[X-1] every cycle except in FALLA. Calls are still latched while s=1.
- INIT:
  - exactly one fX=1 -> piso=X, IDLE.
  - none -> mdw=1 (homing down) until the first fX=1 -> piso=X, mdw=0, IDLE.
  - homing longer than 3*T_VIAJE cycles -> FALLA.
- IDLE:
  - pend[piso-1]=1 -> clear that bit, PUERTA.
  - else if s=0 and a call exists: target chosen by SCAN against last direction (initially up).
    - above -> SUBIR, mup=1 on the same edge.
    - below -> BAJAR, mdw=1 on the same edge.
  - s=1 -> remain IDLE, no motion.
  - a sensor other than f[piso] goes to 1 -> FALLA.
- SUBIR (BAJAR symmetric):
  - the only legal new sensor is f[piso+1] (f[piso-1] for BAJAR). On its rising sample, piso increments and the travel timer clears.
  - if pend for the new floor is set -> clear it, mup=0, PUERTA.
  - otherwise continue (passing floor 2).
  - any other sensor rising (e.g. f3 while travelling 1->2) -> FALLA.
  - travel timer reaching T_VIAJE -> FALLA.
  - s ignored while moving.
- PUERTA:
  - motors off; count T_PUERTA cycles, then IDLE.
  - if s=1 at expiry, hold in PUERTA (re-check each cycle).
  - a call for piso during PUERTA is cleared and restarts the dwell count.
- FALLA: mup=mdw=0, falla=1, pend cleared and frozen; exit only via reset.
- Reset asserted mid-travel: motors drop immediately (asynchronous); re-home via INIT.
- Same-cycle events: sensor arrival and a new call in the same cycle are both taken. A conflict has priority over everything else.

Optional Feature:
Macro ELEV_AUTO_RETORNO_EN.
- Defined: in IDLE with pend=000, s=0 and piso!=1 for T_RETORNO consecutive cycles, pend[0] is set internally, so the car returns to floor 1. Any call resets the idle counter.
- Undefined: the car stays parked indefinitely; parameter T_RETORNO is unused.

Test Plan:
1. Reset with f1=1 -> est=INIT then IDLE, piso=1, mup=mdw=0. Pulse p3 -> SUBIR, mup=1; f2 passes without a stop; f3=1 -> piso=3, PUERTA for 8 cycles, pend=000, then IDLE.
2. Parked at floor 1 with s=1; pulse p1, p2, p3 one at a time -> p1 cleared via PUERTA, pend=110, no motion while s=1. Drop s=0 -> SUBIR; stop at 2, then 3.
3. At floor 1, p2 pulsed, SUBIR; f1->0, then f3=1 before f2 -> FALLA, falla=1, mup=0. Further calls ignored until reset.
4. Reset with no sensor active -> INIT, mdw=1; f1=1 after 30 cycles -> IDLE, piso=1. Then f2 asserted while parked -> FALLA.
5. Parked at floor 3; p2 pulsed -> BAJAR. f3->0, no sensor for 40 cycles -> FALLA by timeout. Separately, reset while f1 and f2 are both 1 -> FALLA directly from INIT.
6. ELEV_AUTO_RETORNO_EN defined, parked at floor 3, no calls -> after 64 cycles pend[0]=1, BAJAR to floor 1. With the macro undefined -> stays IDLE at floor 3.

Source files
------------

// File: rtl/elevador_planificador.sv
// Call scheduler and motion sequencer for a 3-floor elevator.
// Latches calls, tracks the floor from the sensors, selects targets with a SCAN
// policy, drives the motor up/down commands and latches a sticky fault.
// Optional feature macro: ELEV_AUTO_RETORNO_EN (auto-return to floor 1 when idle).
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   p1..p3            call buttons (level sampled sets the pending bit)
//   f1..f3            floor sensors (1 = car at that floor)
//   s                 overweight sensor
//   mup, mdw          motor up / down commands
//   piso              current/last floor 1..3, 0 = unknown
//   pend              pending calls, bit0 = floor 1
//   falla             sticky fault flag
//   est               state: INIT=0 IDLE=1 SUBIR=2 BAJAR=3 PUERTA=4 FALLA=5
module elevador_planificador #(
  parameter int unsigned T_VIAJE   = 40,
  parameter int unsigned T_PUERTA  = 8,
  parameter int unsigned T_RETORNO = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1,
  input  logic       p2,
  input  logic       p3,
  input  logic       f1,
  input  logic       f2,
  input  logic       f3,
  input  logic       s,
  output logic       mup,
  output logic       mdw,
  output logic [1:0] piso,
  output logic [2:0] pend,
  output logic       falla,
  output logic [2:0] est
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    SUBIR  = 3'd2,
    BAJAR  = 3'd3,
    PUERTA = 3'd4,
    FALLA  = 3'd5
  } estado_t;

  localparam int unsigned T_HOMING = 3 * T_VIAJE;
  localparam int unsigned T_MAX    = (T_HOMING > T_PUERTA) ? T_HOMING : T_PUERTA;
  localparam int unsigned TW       = $clog2(T_MAX + 1);

  estado_t       estado_q, estado_nx;
  logic [TW-1:0] tmr_q, tmr_nx, tmr_inc;
  logic          dir_q, dir_nx;          // last travel direction, 1 = up
  logic [2:0]    f_q;                    // previous sensor sample, for edge detection
  logic [1:0]    piso_nx;
  logic [2:0]    pend_nx;
  logic          mup_nx, mdw_nx, falla_nx;

  logic [2:0] f, c, calls, rising;
  logic [2:0] cur_m, up_m, dn_m, above_m, below_m;
  logic       conflict, go_up, ret_hit;

  // Floor number to one-hot sensor mask (0 -> no floor)
  function automatic logic [2:0] mask(input logic [1:0] x);
    case (x)
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b010;
      2'd3:    mask = 3'b100;
      default: mask = 3'b000;
    endcase
  endfunction

  // One-hot sensor vector to floor number
  function automatic logic [1:0] enc(input logic [2:0] v);
    if (v[0])      enc = 2'd1;
    else if (v[1]) enc = 2'd2;
    else if (v[2]) enc = 2'd3;
    else           enc = 2'd0;
  endfunction

  assign f        = {f3, f2, f1};
  assign c        = {p3, p2, p1};
  assign calls    = pend | c;
  assign rising   = f & ~f_q;
  assign conflict = (f[0] & f[1]) | (f[0] & f[2]) | (f[1] & f[2]);
  assign cur_m    = mask(piso);
  assign up_m     = {cur_m[1:0], 1'b0};
  assign dn_m     = {1'b0, cur_m[2:1]};
  assign above_m  = {cur_m[1] | cur_m[0], cur_m[0], 1'b0};
  assign below_m  = {1'b0, cur_m[2], cur_m[2] | cur_m[1]};
  assign tmr_inc  = tmr_q + TW'(1);
  assign est      = estado_q;

  // SCAN: keep the last direction while calls lie ahead, otherwise reverse
  assign go_up = dir_q ? (|(pend & above_m)) : ~(|(pend & below_m));

`ifdef ELEV_AUTO_RETORNO_EN
  localparam int unsigned RW = $clog2(T_RETORNO + 1);
  logic [RW-1:0] ret_q, ret_nx, ret_inc;

  assign ret_inc = ret_q + RW'(1);

  // Idle-parked counter; any call or activity restarts it
  always_comb begin
    ret_nx  = '0;
    ret_hit = 1'b0;
    if (estado_q == IDLE && pend == 3'b000 && c == 3'b000 && !s && piso != 2'd1) begin
      if (ret_inc == RW'(T_RETORNO)) ret_hit = 1'b1;
      else                           ret_nx  = ret_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ret_q <= '0;
    else       ret_q <= ret_nx;
  end
`else
  logic unused_retorno;
  assign ret_hit        = 1'b0;
  assign unused_retorno = (T_RETORNO == 0);
`endif

  // Next-state and next-output logic
  always_comb begin
    estado_nx = estado_q;
    piso_nx   = piso;
    pend_nx   = calls;
    mup_nx    = 1'b0;
    mdw_nx    = 1'b0;
    falla_nx  = 1'b0;
    tmr_nx    = tmr_q;
    dir_nx    = dir_q;

    case (estado_q)
      INIT: begin
        if (f == 3'b000) begin
          // homing downwards until a floor sensor shows up
          mdw_nx = 1'b1;
          tmr_nx = tmr_inc;
          if (tmr_inc == TW'(T_HOMING)) estado_nx = FALLA;
        end else begin
          piso_nx   = enc(f);
          tmr_nx    = '0;
          estado_nx = IDLE;
        end
      end

      IDLE: begin
        if (|(f & ~cur_m)) begin
          estado_nx = FALLA;
        end else if (|(pend & cur_m)) begin
          pend_nx   = calls & ~cur_m;
          tmr_nx    = '0;
          estado_nx = PUERTA;
        end else if (!s && pend != 3'b000) begin
          tmr_nx = '0;
          dir_nx = go_up;
          if (go_up) begin
            mup_nx    = 1'b1;
            estado_nx = SUBIR;
          end else begin
            mdw_nx    = 1'b1;
            estado_nx = BAJAR;
          end
        end
        if (ret_hit) pend_nx[0] = 1'b1;
      end

      SUBIR: begin
        if (|(rising & ~up_m)) begin
          estado_nx = FALLA;
        end else if (|(rising & up_m)) begin
          piso_nx = piso + 2'd1;
          tmr_nx  = '0;
          if (|(calls & up_m)) begin
            pend_nx   = calls & ~up_m;
            estado_nx = PUERTA;
          end else if (up_m[2]) begin
            estado_nx = IDLE;        // top floor, nothing left to serve upwards
          end else begin
            mup_nx = 1'b1;
          end
        end else begin
          mup_nx = 1'b1;
          tmr_nx = tmr_inc;
          if (tmr_inc == TW'(T_VIAJE)) estado_nx = FALLA;
        end
      end

      BAJAR: begin
        if (|(rising & ~dn_m)) begin
          estado_nx = FALLA;
        end else if (|(rising & dn_m)) begin
          piso_nx = piso - 2'd1;
          tmr_nx  = '0;
          if (|(calls & dn_m)) begin
            pend_nx   = calls & ~dn_m;
            estado_nx = PUERTA;
          end else if (dn_m[0]) begin
            estado_nx = IDLE;
          end else begin
            mdw_nx = 1'b1;
          end
        end else begin
          mdw_nx = 1'b1;
          tmr_nx = tmr_inc;
          if (tmr_inc == TW'(T_VIAJE)) estado_nx = FALLA;
        end
      end

      PUERTA: begin
        if (|(c & cur_m)) begin
          // a call for this floor reopens the door
          pend_nx = calls & ~cur_m;
          tmr_nx  = '0;
        end else if (tmr_q == TW'(T_PUERTA - 1)) begin
          if (!s) begin
            tmr_nx    = '0;
            estado_nx = IDLE;
          end
        end else begin
          tmr_nx = tmr_inc;
        end
      end

      FALLA:   estado_nx = FALLA;
      default: estado_nx = FALLA;
    endcase

    // Sensor conflict overrides everything outside FALLA
    if (conflict && estado_q != FALLA) estado_nx = FALLA;

    if (estado_nx == FALLA) begin
      mup_nx   = 1'b0;
      mdw_nx   = 1'b0;
      falla_nx = 1'b1;
      pend_nx  = 3'b000;
      tmr_nx   = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= INIT;
      tmr_q    <= '0;
      dir_q    <= 1'b1;
      f_q      <= 3'b000;
      piso     <= 2'd0;
      pend     <= 3'b000;
      mup      <= 1'b0;
      mdw      <= 1'b0;
      falla    <= 1'b0;
    end else begin
      estado_q <= estado_nx;
      tmr_q    <= tmr_nx;
      dir_q    <= dir_nx;
      f_q      <= f;
      piso     <= piso_nx;
      pend     <= pend_nx;
      mup      <= mup_nx;
      mdw      <= mdw_nx;
      falla    <= falla_nx;
    end
  end

endmodule

// File: tb/tb_elevador_planificador.sv
// Directed self-checking bench for elevador_planificador.
module tb_elevador_planificador;

  logic       clk, reset;
  logic       p1, p2, p3, f1, f2, f3, s;
  logic       mup, mdw, falla;
  logic [1:0] piso;
  logic [2:0] pend, est;

  int n_cmp = 0;
  int n_err = 0;

  elevador_planificador dut (
    .clk   (clk),
    .reset (reset),
    .p1    (p1),
    .p2    (p2),
    .p3    (p3),
    .f1    (f1),
    .f2    (f2),
    .f3    (f3),
    .s     (s),
    .mup   (mup),
    .mdw   (mdw),
    .piso  (piso),
    .pend  (pend),
    .falla (falla),
    .est   (est)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_f(input logic [2:0] v);
    {f3, f2, f1} = v;
  endtask

  task automatic do_reset(input logic [2:0] v);
    reset = 1'b1;
    {p3, p2, p1} = 3'b000;
    s = 1'b0;
    set_f(v);
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {p3, p2, p1} = 3'b000;
    s = 1'b0;
    set_f(3'b001);
    step(2);

    // 1: reset state, trip 1 -> 3 passing floor 2
    chk("rst_est",   8'(est),   8'd0);
    chk("rst_mup",   8'(mup),   8'd0);
    chk("rst_mdw",   8'(mdw),   8'd0);
    chk("rst_piso",  8'(piso),  8'd0);
    chk("rst_pend",  8'(pend),  8'd0);
    chk("rst_falla", 8'(falla), 8'd0);
    reset = 1'b0;
    step(1);
    chk("t1_idle_est",  8'(est),  8'd1);
    chk("t1_idle_piso", 8'(piso), 8'd1);
    p3 = 1'b1; step(1); p3 = 1'b0;
    chk("t1_pend_p3", 8'(pend), 8'b100);
    step(1);
    chk("t1_subir_est", 8'(est), 8'd2);
    chk("t1_subir_mup", 8'(mup), 8'd1);
    set_f(3'b000); step(1);
    set_f(3'b010); step(1);
    chk("t1_pass2_est",  8'(est),  8'd2);
    chk("t1_pass2_piso", 8'(piso), 8'd2);
    chk("t1_pass2_mup",  8'(mup),  8'd1);
    set_f(3'b000); step(1);
    set_f(3'b100); step(1);
    chk("t1_arr3_est",  8'(est),  8'd4);
    chk("t1_arr3_piso", 8'(piso), 8'd3);
    chk("t1_arr3_mup",  8'(mup),  8'd0);
    chk("t1_arr3_pend", 8'(pend), 8'd0);
    step(7);
    chk("t1_dwell7_est", 8'(est), 8'd4);
    step(1);
    chk("t1_dwell8_est", 8'(est), 8'd1);

    // 2: overweight holds the door, then serve floors 2 and 3
    do_reset(3'b001);
    s = 1'b1;
    step(1);
    chk("t2_idle_est", 8'(est), 8'd1);
    p1 = 1'b1; step(1); p1 = 1'b0;
    chk("t2_pend_p1", 8'(pend), 8'b001);
    step(1);
    chk("t2_door_est",  8'(est),  8'd4);
    chk("t2_door_pend", 8'(pend), 8'd0);
    p2 = 1'b1; step(1); p2 = 1'b0;
    p3 = 1'b1; step(1); p3 = 1'b0;
    step(10);
    chk("t2_hold_est",  8'(est),  8'd4);
    chk("t2_hold_pend", 8'(pend), 8'b110);
    chk("t2_hold_mup",  8'(mup),  8'd0);
    s = 1'b0;
    step(1);
    chk("t2_rel_est", 8'(est), 8'd1);
    step(1);
    chk("t2_up_est", 8'(est), 8'd2);
    chk("t2_up_mup", 8'(mup), 8'd1);
    set_f(3'b000); step(1);
    set_f(3'b010); step(1);
    chk("t2_stop2_est",  8'(est),  8'd4);
    chk("t2_stop2_piso", 8'(piso), 8'd2);
    chk("t2_stop2_pend", 8'(pend), 8'b100);
    step(8);
    chk("t2_idle2_est", 8'(est), 8'd1);
    step(1);
    chk("t2_up2_est", 8'(est), 8'd2);
    set_f(3'b000); step(1);
    set_f(3'b100); step(1);
    chk("t2_stop3_est",  8'(est),  8'd4);
    chk("t2_stop3_piso", 8'(piso), 8'd3);
    chk("t2_stop3_pend", 8'(pend), 8'd0);

    // 3: skipped floor while travelling -> sticky fault
    do_reset(3'b001);
    step(1);
    p2 = 1'b1; step(1); p2 = 1'b0;
    step(1);
    chk("t3_subir_est", 8'(est), 8'd2);
    set_f(3'b000); step(1);
    set_f(3'b100); step(1);
    chk("t3_falla_est", 8'(est),   8'd5);
    chk("t3_falla_flg", 8'(falla), 8'd1);
    chk("t3_falla_mup", 8'(mup),   8'd0);
    p1 = 1'b1; step(1); p1 = 1'b0;
    step(1);
    chk("t3_frozen_pend", 8'(pend), 8'd0);
    chk("t3_frozen_est",  8'(est),  8'd5);

    // reset mid-travel drops the motor without a clock edge
    do_reset(3'b001);
    step(1);
    p2 = 1'b1; step(1); p2 = 1'b0;
    step(1);
    chk("rm_mup_before", 8'(mup), 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("rm_mup_after", 8'(mup), 8'd0);
    chk("rm_est_after", 8'(est), 8'd0);

    // 4: homing down, then a foreign sensor while parked
    do_reset(3'b000);
    step(1);
    chk("t4_home_est", 8'(est), 8'd0);
    chk("t4_home_mdw", 8'(mdw), 8'd1);
    step(29);
    chk("t4_home30_est", 8'(est), 8'd0);
    set_f(3'b001); step(1);
    chk("t4_homed_est",  8'(est),  8'd1);
    chk("t4_homed_piso", 8'(piso), 8'd1);
    chk("t4_homed_mdw",  8'(mdw),  8'd0);
    set_f(3'b010); step(1);
    chk("t4_foreign_est", 8'(est), 8'd5);

    // homing timeout boundary at 3*T_VIAJE = 120 cycles
    do_reset(3'b000);
    step(119);
    chk("ht_119_est", 8'(est), 8'd0);
    chk("ht_119_mdw", 8'(mdw), 8'd1);
    step(1);
    chk("ht_120_est", 8'(est), 8'd5);
    chk("ht_120_mdw", 8'(mdw), 8'd0);

    // 5: travel timeout going down, and conflict out of INIT
    do_reset(3'b100);
    step(1);
    chk("t5_idle_piso", 8'(piso), 8'd3);
    p2 = 1'b1; step(1); p2 = 1'b0;
    step(1);
    chk("t5_bajar_est", 8'(est), 8'd3);
    chk("t5_bajar_mdw", 8'(mdw), 8'd1);
    set_f(3'b000);
    step(39);
    chk("t5_39_est", 8'(est), 8'd3);
    step(1);
    chk("t5_40_est",   8'(est),   8'd5);
    chk("t5_40_mdw",   8'(mdw),   8'd0);
    chk("t5_40_falla", 8'(falla), 8'd1);
    do_reset(3'b011);
    step(1);
    chk("t5_conf_est",   8'(est),   8'd5);
    chk("t5_conf_falla", 8'(falla), 8'd1);

    // 6: parked at floor 3 with no calls
    do_reset(3'b100);
    step(1);
`ifdef ELEV_AUTO_RETORNO_EN
    step(63);
    chk("t6_ret63_pend", 8'(pend), 8'd0);
    step(1);
    chk("t6_ret64_pend", 8'(pend), 8'b001);
    step(1);
    chk("t6_ret_est", 8'(est), 8'd3);
`else
    step(80);
    chk("t6_park_est",  8'(est),  8'd1);
    chk("t6_park_pend", 8'(pend), 8'd0);
    chk("t6_park_piso", 8'(piso), 8'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
